rs232_avm_uart: RTL and testbench
=================================

Name: rs232_avm_uart

Overview:
Avalon-MM slave UART (8N1) that sits directly upstream of the RSA wrapper and serves as its only I/O path to the host PC. It exposes RX data, TX data and status registers at byte offsets 0, 4 and 8. It deserialises host bytes (key N, key D, ciphertext) into a one-byte RX holding register. It serialises plaintext bytes written by the wrapper onto uart_txd.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
ADDR_W, 5, Avalon address width in bits.

Ports:
avm_clk  input  1  system clock; all logic is rising-edge.
avm_rst  input  1  asynchronous reset, active-high.
avs_address  input  ADDR_W  byte address: 0=RX, 4=TX, 8=STATUS.
avs_read  input  1  read request.
avs_readdata  output  32  read data.
avs_write  input  1  write request.
avs_writedata  input  32  write data; only bits [7:0] are used.
avs_waitrequest  output  1  stall; the transfer completes in the cycle where request=1 and waitrequest=0.
uart_rxd  input  1  serial in, asynchronous to avm_clk, idle high.
uart_txd  output  1  serial out, idle high.

Behaviour:
- Reset: one clock domain (avm_clk); reset is asynchronous and active-high on avm_rst.
  - uart_txd=1, avs_readdata=0, avs_waitrequest=0.
  - rx_ready=0, tx_ready=1, overrun=0.
  - RX FSM and TX FSM in IDLE; all counters 0.
  - Reset mid-frame aborts the frame silently; nothing is latched or emitted.
- Bus timing: exactly one wait state per transfer.
  - ack_r <= (avs_read|avs_write) & ~ack_r.
  - avs_waitrequest = (avs_read|avs_write) & ~ack_r.
  - A master holding avs_read high continuously therefore completes one transfer every 2 cycles.
  - readdata is registered, valid in the completion cycle, and 0 otherwise.
  - All side effects occur only in the completion cycle.
- Read map:
  - 0: {24'b0, rx_data}. Completion clears rx_ready and overrun.
  - 8: {23'b0, overrun, rx_ready, tx_ready, 6'b0}, i.e. bit7=rx_ready, bit6=tx_ready, bit8=overrun. No side effect.
  - 4 and any other address: 0.
- Write map:
  - 4: if tx_ready, latch writedata[7:0], clear tx_ready and start TX. If TX is busy, the write is dropped; it still completes with one wait state.
  - Writes to all other addresses are ignored.
- RX path:
  - 2-FF synchroniser on uart_rxd.
  - States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronised line goes to START and clears the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the line is high, it is a false start: return to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - Sample=1: rx_data <= shift register; if rx_ready was already 1, set overrun; then set rx_ready. Back to IDLE.
    - Sample=0 (framing error): discard the byte, flags unchanged. Wait for the line high, then IDLE.
  - If a new byte lands in the same cycle as the RX read completes, the new byte wins: rx_ready stays 1 and overrun is not set.
- TX path:
  - States: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each bit is held for exactly CLKS_PER_BIT cycles: start bit 0, then 8 data bits LSB first, then stop bit 1.
  - tx_ready rises in the cycle the STOP state ends.
  - Latency: first start-bit cycle on uart_txd is the cycle after the write completes.
  - One frame = 10*CLKS_PER_BIT cycles.
- Width rules: baud counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1. Bit counters are 3 bits.
- RX and TX are fully independent; simultaneous RX and TX operation is required.

Test Plan:
- Reset then read STATUS -> waitrequest high 1 cycle, then readdata=0x40 (tx_ready=1, rx_ready=0); uart_txd=1.
- CLKS_PER_BIT=8, drive frame for 0xA5 on uart_rxd -> STATUS reads 0xC0; RX read returns 0xA5; STATUS then reads 0x40.
- Two frames 0x12 then 0x34 with no RX read in between -> RX=0x34, STATUS=0x1C0; after RX read, STATUS=0x40.
- Write 0x5A to address 4 -> uart_txd shows 0,0,1,0,1,1,0,1,0,1 at 8 cycles per bit; tx_ready=0 during the frame and 1 after 80 cycles.
- Second write of 0xFF while TX is busy -> dropped; only the 0x5A frame appears.
- 4-cycle low glitch on uart_rxd, or a frame with stop bit=0 -> rx_ready stays 0.
- Reset asserted mid TX frame -> uart_txd=1 immediately; tx_ready=1.

Source files
------------

// File: rtl/rs232_avm_uart.sv
// rtl/rs232_avm_uart.sv - Avalon-MM slave 8N1 UART with RX, TX and STATUS registers
module rs232_avm_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 5
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              avs_waitrequest,
  input  logic              uart_rxd,
  output logic              uart_txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [ADDR_W-1:0] ADDR_RX   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TX   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(8);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Only the low byte of a write carries data.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:8];

  // ---------------------------------------------------------------
  // Bus interface: every transfer takes exactly one wait state
  // ---------------------------------------------------------------
  logic        ack_r;
  logic        bus_req;
  logic        rd_done;
  logic        wr_done;
  logic        rx_rd_done;
  logic        tx_start;
  logic [31:0] rd_mux;

  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        overrun;
  logic        tx_ready;

  assign bus_req         = avs_read | avs_write;
  assign avs_waitrequest = bus_req & ~ack_r;
  assign rd_done         = avs_read & ack_r;
  assign wr_done         = avs_write & ack_r;
  assign rx_rd_done      = rd_done & (avs_address == ADDR_RX);
  assign tx_start        = wr_done & (avs_address == ADDR_TX) & tx_ready;

  // Alternates the acknowledge so a held request completes every other cycle
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) ack_r <= 1'b0;
    else         ack_r <= bus_req & ~ack_r;
  end

  // Register map decode for reads
  always_comb begin
    rd_mux = '0;
    if (avs_address == ADDR_RX)
      rd_mux = {24'b0, rx_data};
    else if (avs_address == ADDR_STAT)
      rd_mux = {23'b0, overrun, rx_ready, tx_ready, 6'b0};
  end

  // Read data is captured in the wait cycle so it is valid only in the completion cycle
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)                   avs_readdata <= '0;
    else if (avs_read & ~ack_r)    avs_readdata <= rd_mux;
    else                           avs_readdata <= '0;
  end

  // ---------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  rx_state_t        rx_state;
  rx_state_t        rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick;
  logic             rx_half;
  logic             rx_cnt_clr;
  logic             rx_bit_clr;
  logic             rx_shift_en;
  logic             rx_done;

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_tick = (rx_cnt == CNT_MAX);
  assign rx_half = (rx_cnt == CNT_HALF);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // RX next-state logic; a framing error parks in BREAK until the line returns high
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX control strobes decoded from the current state and baud counter
  always_comb begin
    rx_cnt_clr  = 1'b1;
    rx_bit_clr  = 1'b0;
    rx_shift_en = 1'b0;
    rx_done     = 1'b0;
    case (rx_state)
      RX_IDLE:  rx_bit_clr = rx_fall;
      RX_START: rx_cnt_clr = rx_half;
      RX_DATA: begin
        rx_cnt_clr  = rx_tick;
        rx_shift_en = rx_tick;
      end
      RX_STOP: begin
        rx_cnt_clr = rx_tick;
        rx_done    = rx_tick & rx_sync;
      end
      default: rx_cnt_clr = 1'b1;
    endcase
  end

  // RX baud counter, bit counter and LSB-first shift register
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_cnt_clr) rx_cnt <= '0;
      else            rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_bit_clr)       rx_bit <= '0;
      else if (rx_shift_en) rx_bit <= rx_bit + 3'd1;
      if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // RX holding register and flags; a byte landing with a read completion wins
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_data  <= '0;
      rx_ready <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_ready <= 1'b1;
      end else if (rx_rd_done) begin
        rx_ready <= 1'b0;
      end
      if (rx_rd_done)               overrun <= 1'b0;
      else if (rx_done && rx_ready) overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------
  tx_state_t        tx_state;
  tx_state_t        tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_tick;
  logic             tx_cnt_clr;
  logic             tx_shift_en;
  logic             tx_frame_end;

  assign tx_tick = (tx_cnt == CNT_MAX);

  // TX state register
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  // TX next-state logic; every state is held for whole bit periods
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX line level and control strobes decoded from the current state
  always_comb begin
    uart_txd     = 1'b1;
    tx_cnt_clr   = 1'b1;
    tx_shift_en  = 1'b0;
    tx_frame_end = 1'b0;
    case (tx_state)
      TX_START: begin
        uart_txd   = 1'b0;
        tx_cnt_clr = tx_tick;
      end
      TX_DATA: begin
        uart_txd    = tx_shift[0];
        tx_cnt_clr  = tx_tick;
        tx_shift_en = tx_tick;
      end
      TX_STOP: begin
        uart_txd     = 1'b1;
        tx_cnt_clr   = tx_tick;
        tx_frame_end = tx_tick;
      end
      default: uart_txd = 1'b1;
    endcase
  end

  // TX baud counter, bit counter, shift register and ready flag
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (tx_cnt_clr) tx_cnt <= '0;
      else            tx_cnt <= tx_cnt + CNT_W'(1);
      if (tx_start)         tx_bit <= '0;
      else if (tx_shift_en) tx_bit <= tx_bit + 3'd1;
      if (tx_start)         tx_shift <= avs_writedata[7:0];
      else if (tx_shift_en) tx_shift <= {1'b1, tx_shift[7:1]};
      if (tx_start)          tx_ready <= 1'b0;
      else if (tx_frame_end) tx_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs232_avm_uart.sv
// tb/tb_rs232_avm_uart.sv - self-checking bench for rs232_avm_uart
module tb_rs232_avm_uart;

  localparam int CPB = 8;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_waitrequest;
  logic          uart_rxd = 1'b1;
  logic          uart_txd;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_avm_uart #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .avm_clk        (clk),
    .avm_rst        (rst),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .uart_rxd       (uart_rxd),
    .uart_txd       (uart_txd)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rd_nz  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    d = '0;
    waits = 0;
    @(negedge clk);
    avs_address = a;
    avs_read = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (!avs_waitrequest) begin
        d = avs_readdata;
        done = 1'b1;
      end else begin
        if (avs_readdata !== 32'h0) rd_nz++;
        waits++;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_read_timeout: got no completion expected completion within 8 cycles");
    end
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] wd, output int comp_cyc,
                           output int waits);
    bit done;
    done = 1'b0;
    comp_cyc = 0;
    waits = 0;
    @(negedge clk);
    avs_address = a;
    avs_writedata = wd;
    avs_write = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (!avs_waitrequest) begin
        comp_cyc = cyc;
        done = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_write_timeout: got no completion expected completion within 8 cycles");
    end
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    bus_read(a, d, w);
    check(name, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  // Line-level TX decoder: finds a start bit, samples mid-bit, records byte and start cycle
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int         tx_bad = 0;
  logic [9:0] mon_bits;
  int         mon_start;
  bit         mon_ok;

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        mon_start = cyc;
        mon_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < ((b == 0) ? (CPB / 2 - 1) : CPB); k++) begin
            @(negedge clk);
            if (rst) mon_ok = 1'b0;
          end
          mon_bits[b] = uart_txd;
        end
        if (mon_ok) begin
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) tx_bad++;
          else begin
            tx_q.push_back(mon_bits[8:1]);
            tx_cyc_q.push_back(mon_start);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL global_timeout: got no end of test expected end before 60000 cycles");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] d;
  int          w;
  int          wc;
  int          wc2;
  int          w2;
  int          wave_bad;
  logic [9:0]  tx_frame;
  logic [5:0]  wpat;
  logic [7:0]  exp_tx[$];
  int          nfr;
  bit          do_tx;
  bit          extra;
  logic [7:0]  tx_b;
  logic [7:0]  fb[2];
  bit          fs[2];
  int          fg[2];
  int          good_cnt;
  bit          known;
  logic [7:0]  last_good;
  logic [31:0] exp_stat;

  initial begin : main
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_txd", uart_txd, 1);
    check("reset_waitrequest", avs_waitrequest, 0);
    check("reset_readdata", avs_readdata, 0);
    @(negedge clk);
    rst = 1'b0;

    bus_read(AW'(8), d, w);
    check("reset_status", d, 32'h40);
    check("reset_status_waits", w, 1);
    check("idle_txd", uart_txd, 1);

    // Register map vectors with TX idle and no RX traffic
    vt[0] = '{0, AW'(8),  32'h0,        32'h40};
    vt[1] = '{0, AW'(0),  32'h0,        32'h0};
    vt[2] = '{0, AW'(4),  32'h0,        32'h0};
    vt[3] = '{1, AW'(0),  32'hAB,       32'h0};
    vt[4] = '{0, AW'(0),  32'h0,        32'h0};
    vt[5] = '{1, AW'(8),  32'hFFFFFFFF, 32'h0};
    vt[6] = '{0, AW'(8),  32'h0,        32'h40};
    vt[7] = '{0, AW'(12), 32'h0,        32'h0};
    vt[8] = '{0, AW'(31), 32'h0,        32'h0};
    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) begin
        bus_write(vt[i].addr, vt[i].wdata, wc, w);
        check($sformatf("vec%0d_write_waits", i), w, 1);
      end else begin
        bus_read(vt[i].addr, d, w);
        check($sformatf("vec%0d_readdata", i), d, vt[i].exp);
        check($sformatf("vec%0d_read_waits", i), w, 1);
      end
    end

    // Held read: one completion every other cycle
    @(negedge clk);
    avs_address = AW'(8);
    avs_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      wpat[k] = avs_waitrequest;
      if (!avs_waitrequest) check($sformatf("held_read_data%0d", k), avs_readdata, 32'h40);
      @(negedge clk);
    end
    avs_read = 1'b0;
    check("held_read_waitpattern", wpat, 6'b010101);

    // Single RX byte
    send_frame(8'hA5, 1'b1);
    repeat (12) @(negedge clk);
    rd_chk("rx_a5_status", AW'(8), 32'hC0);
    rd_chk("rx_a5_data", AW'(0), 32'hA5);
    rd_chk("rx_a5_status_after", AW'(8), 32'h40);

    // Overrun: two bytes without a read
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (12) @(negedge clk);
    rd_chk("rx_ovr_status", AW'(8), 32'h1C0);
    rd_chk("rx_ovr_data", AW'(0), 32'h34);
    rd_chk("rx_ovr_status_after", AW'(8), 32'h40);

    // Short glitch is a false start
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk("rx_glitch_status", AW'(8), 32'h40);

    // Framing error discards the byte, then a good frame still lands
    send_frame(8'h77, 1'b0);
    repeat (12) @(negedge clk);
    rd_chk("rx_frame_err_status", AW'(8), 32'h40);
    send_frame(8'h3C, 1'b1);
    repeat (12) @(negedge clk);
    rd_chk("rx_recover_status", AW'(8), 32'hC0);
    rd_chk("rx_recover_data", AW'(0), 32'h3C);

    // TX 0x5A: exact per-cycle waveform, busy write dropped
    tx_frame = {1'b1, 8'h5A, 1'b0};
    wave_bad = 0;
    bus_write(AW'(4), 32'h5A, wc, w);
    fork
      begin
        for (int k = 0; k < 10 * CPB; k++) begin
          @(negedge clk);
          if (uart_txd !== tx_frame[k / CPB]) wave_bad++;
        end
      end
      begin
        repeat (4) @(negedge clk);
        bus_write(AW'(4), 32'hFF, wc2, w2);
        check("tx_busy_write_waits", w2, 1);
        rd_chk("tx_busy_status", AW'(8), 32'h0);
      end
    join
    check("tx_5a_wave_bad_cycles", wave_bad, 0);
    rd_chk("tx_done_status", AW'(8), 32'h40);
    repeat (100) @(negedge clk);
    check("tx_5a_frame_count", tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      check("tx_5a_byte", tx_q[0], 8'h5A);
      check("tx_5a_latency", tx_cyc_q[0], wc + 1);
    end
    tx_q.delete();
    tx_cyc_q.delete();

    // Reset in the middle of a TX frame
    bus_write(AW'(4), 32'hC3, wc, w);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midtx_reset_txd", uart_txd, 1);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("midtx_reset_status", AW'(8), 32'h40);
    repeat (100) @(negedge clk);
    check("midtx_reset_no_frame", tx_q.size(), 0);
    tx_q.delete();
    tx_cyc_q.delete();

    // Randomized concurrent RX/TX against a frame-level model
    good_cnt = 0;
    known = 1'b0;
    last_good = '0;
    for (int it = 0; it < 14; it++) begin
      nfr   = $urandom_range(0, 2);
      do_tx = 1'($urandom_range(0, 1));
      extra = 1'($urandom_range(0, 1));
      tx_b  = 8'($urandom);
      for (int k = 0; k < 2; k++) begin
        fb[k] = 8'($urandom);
        fs[k] = ($urandom_range(0, 3) != 0);
        fg[k] = fs[k] ? $urandom_range(0, 3) : 4 + $urandom_range(0, 3);
      end
      fork
        begin
          for (int k = 0; k < nfr; k++) begin
            send_frame(fb[k], fs[k]);
            repeat (fg[k]) @(negedge clk);
          end
        end
        begin
          if (do_tx) begin
            bus_write(AW'(4), {24'h0, tx_b}, wc, w);
            exp_tx.push_back(tx_b);
            if (extra) bus_write(AW'(4), {24'h0, ~tx_b}, wc2, w2);
          end
        end
      join
      repeat (100) @(negedge clk);
      for (int k = 0; k < nfr; k++) begin
        if (fs[k]) begin
          good_cnt++;
          last_good = fb[k];
          known = 1'b1;
        end
      end
      exp_stat = 32'h40 | ((good_cnt > 0) ? 32'h80 : 32'h0) | ((good_cnt > 1) ? 32'h100 : 32'h0);
      rd_chk($sformatf("rand%0d_status", it), AW'(8), exp_stat);
      bus_read(AW'(0), d, w);
      if (known) check($sformatf("rand%0d_rxdata", it), d, {24'h0, last_good});
      good_cnt = 0;
      rd_chk($sformatf("rand%0d_status_after", it), AW'(8), 32'h40);
    end
    check("rand_tx_frame_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("rand_tx_byte%0d", i), tx_q[i], exp_tx[i]);

    check("tx_framing_errors", tx_bad, 0);
    check("readdata_nonzero_outside_completion", rd_nz, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
